// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA-side per-frame control blocks.
// Geometry of the active area, motion FSM states and edge_hit bit positions.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_CALC,
    ST_COMMIT
  } motion_state_e;

  localparam int EDGE_L = 3;
  localparam int EDGE_R = 2;
  localparam int EDGE_T = 1;
  localparam int EDGE_B = 0;

endpackage

// File: rtl/vga_frame_tick.sv
// One-cycle registered pulse at the first pixel of the first blanking line.
// Shared by any block that needs a once-per-frame event from vga_timing.
module vga_frame_tick
  import vga_pkg::*;
#(
  parameter int unsigned TICK_LINE = V_ACTIVE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] h_cnt_i,
  input  logic [9:0] v_cnt_i,
  output logic       frame_tick_o
);

  logic tick_q, tick_d;

  assign tick_d = (h_cnt_i == 10'd0) && (v_cnt_i == 10'(TICK_LINE));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tick_q <= 1'b0;
    else         tick_q <= tick_d;
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/logo_motion_ctrl.sv
// Bouncing-logo position generator: moves the logo once every FRAMES_PER_STEP
// frames, only during vertical blanking, reflecting off the active-area edges.
module logo_motion_ctrl
  import vga_pkg::*;
#(
  parameter int LOGO_W          = 64,
  parameter int LOGO_H          = 64,
  parameter int INIT_X          = 430,
  parameter int INIT_Y          = 50,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic       pclk_i,
  input  logic       rst_ni,
  input  logic [9:0] h_cnt_i,
  input  logic [9:0] v_cnt_i,
  input  logic       pause_i,
  input  logic [1:0] speed_i,
  output logic [9:0] logo_x_o,
  output logic [9:0] logo_y_o,
  output logic       dir_x_o,
  output logic       dir_y_o,
  output logic       bounce_o,
  output logic [3:0] edge_hit_o
);

  localparam logic signed [10:0] XMAX_S   = 11'(H_ACTIVE - LOGO_W);
  localparam logic signed [10:0] YMAX_S   = 11'(V_ACTIVE - LOGO_H);
  localparam logic [7:0]         CNT_LAST = 8'(FRAMES_PER_STEP - 1);

  motion_state_e     state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              dx_q, dx_d, dy_q, dy_d;
  logic signed [10:0] nx_q, nx_d, ny_q, ny_d;
  logic              bounce_q, bounce_d;
  logic [3:0]        edge_q, edge_d;
  logic [3:0]        hit;
  logic              frame_tick;
  logic signed [10:0] x_s, y_s, step_s;

  vga_frame_tick #(
    .TICK_LINE (V_ACTIVE)
  ) u_frame_tick (
    .clk_i        (pclk_i),
    .rst_ni       (rst_ni),
    .h_cnt_i      (h_cnt_i),
    .v_cnt_i      (v_cnt_i),
    .frame_tick_o (frame_tick)
  );

  assign x_s    = signed'({1'b0, x_q});
  assign y_s    = signed'({1'b0, y_q});
  assign step_s = signed'({9'b0, speed_i}) + 11'sd1;

  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_WAIT;
      cnt_q    <= '0;
      x_q      <= 10'(INIT_X);
      y_q      <= 10'(INIT_Y);
      dx_q     <= 1'b1;
      dy_q     <= 1'b0;
      nx_q     <= '0;
      ny_q     <= '0;
      bounce_q <= 1'b0;
      edge_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      bounce_q <= bounce_d;
      edge_q   <= edge_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    bounce_d = 1'b0;
    edge_d   = edge_q;
    hit      = '0;
    unique case (state_q)
      ST_WAIT: begin
        // pause freezes the frame counter as well as the position
        if (frame_tick && !pause_i) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_CALC;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_CALC: begin
        nx_d    = dx_q ? (x_s + step_s) : (x_s - step_s);
        ny_d    = dy_q ? (y_s + step_s) : (y_s - step_s);
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (dx_q && (nx_q >= XMAX_S)) begin
          x_d         = XMAX_S[9:0];
          dx_d        = 1'b0;
          hit[EDGE_R] = 1'b1;
        end else if (!dx_q && (nx_q <= 11'sd0)) begin
          x_d         = '0;
          dx_d        = 1'b1;
          hit[EDGE_L] = 1'b1;
        end else begin
          x_d = nx_q[9:0];
        end
        if (dy_q && (ny_q >= YMAX_S)) begin
          y_d         = YMAX_S[9:0];
          dy_d        = 1'b0;
          hit[EDGE_B] = 1'b1;
        end else if (!dy_q && (ny_q <= 11'sd0)) begin
          y_d         = '0;
          dy_d        = 1'b1;
          hit[EDGE_T] = 1'b1;
        end else begin
          y_d = ny_q[9:0];
        end
        edge_d   = hit;
        bounce_d = |hit;
        state_d  = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign logo_x_o   = x_q;
  assign logo_y_o   = y_q;
  assign dir_x_o    = dx_q;
  assign dir_y_o    = dy_q;
  assign bounce_o   = bounce_q;
  assign edge_hit_o = edge_q;

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Directed bench for logo_motion_ctrl: table of move vectors with hand-computed
// positions, plus sequences for pause, async reset, latency and a long run.
module tb_logo_motion_ctrl;

  logic       pclk = 1'b0;
  logic       rst_n, rst_c_n;
  logic [9:0] h_cnt, v_cnt;
  logic       pause;
  logic [1:0] speed;

  logic [9:0] x_a, y_a, x_c, y_c;
  logic       dx_a, dy_a, b_a, dx_c, dy_c, b_c;
  logic [3:0] e_a, e_c;

  always #5 pclk = ~pclk;

  logo_motion_ctrl dut (
    .pclk_i(pclk), .rst_ni(rst_n), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt),
    .pause_i(pause), .speed_i(speed),
    .logo_x_o(x_a), .logo_y_o(y_a), .dir_x_o(dx_a), .dir_y_o(dy_a),
    .bounce_o(b_a), .edge_hit_o(e_a)
  );

  // second instance starts where a top-left corner hit is reachable
  logo_motion_ctrl #(.INIT_X(300), .INIT_Y(20)) dut_c (
    .pclk_i(pclk), .rst_ni(rst_c_n), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt),
    .pause_i(pause), .speed_i(speed),
    .logo_x_o(x_c), .logo_y_o(y_c), .dir_x_o(dx_c), .dir_y_o(dy_c),
    .bounce_o(b_c), .edge_hit_o(e_c)
  );

  int         sel;
  logic [9:0] ox, oy;
  logic       odx, ody, ob;
  logic [3:0] oe;

  always_comb begin
    ox = x_a; oy = y_a; odx = dx_a; ody = dy_a; ob = b_a; oe = e_a;
    if (sel == 1) begin
      ox = x_c; oy = y_c; odx = dx_c; ody = dy_c; ob = b_c; oe = e_c;
    end
  end

  typedef struct {
    int sel;
    int spd;
    int frames;
    int ex;
    int ey;
    int edx;
    int edy;
    int eedge;
    int ebcnt;
  } vec_t;

  localparam int NA = 9;
  localparam int NV = 19;
  vec_t tbl[NV];

  int total = 0;
  int bad   = 0;
  int bcnt  = 0;
  int nchg  = 0;
  int mon_en = 0;
  logic [9:0] px, py;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
    if (ob) bcnt++;
    if (mon_en != 0 && (ox != px || oy != py)) begin
      nchg++;
      chk("t6_change_in_blank_and_range",
          int'(v_cnt >= 10'd480 && ox <= 10'd576 && oy <= 10'd416), 1);
    end
    px = ox;
    py = oy;
  endtask

  task automatic run_frame();
    step(); h_cnt = 10'd0; v_cnt = 10'd480;
    step(); h_cnt = 10'd1;
    repeat (8) begin step(); h_cnt = h_cnt + 10'd1; end
    step(); h_cnt = 10'd5; v_cnt = 10'd0;
    step();
  endtask

  task automatic apply(input int k);
    int b0;
    speed = 2'(tbl[k].spd);
    b0 = bcnt;
    repeat (tbl[k].frames) run_frame();
    chk($sformatf("v%0d_x", k), int'(ox), tbl[k].ex);
    chk($sformatf("v%0d_y", k), int'(oy), tbl[k].ey);
    chk($sformatf("v%0d_dir_x", k), int'(odx), tbl[k].edx);
    chk($sformatf("v%0d_dir_y", k), int'(ody), tbl[k].edy);
    chk($sformatf("v%0d_edge_hit", k), int'(oe), tbl[k].eedge);
    chk($sformatf("v%0d_bounce_cycles", k), bcnt - b0, tbl[k].ebcnt);
  endtask

  initial begin
    int lat;
    int b0;
    //            sel spd frm   x    y  dx dy edge bcnt
    tbl[0]  = '{0, 0,   1, 430,  50, 1, 0, 0, 0};
    tbl[1]  = '{0, 0,   1, 431,  49, 1, 0, 0, 0};
    tbl[2]  = '{0, 0,   6, 434,  46, 1, 0, 0, 0};
    tbl[3]  = '{0, 3,  22, 478,   2, 1, 0, 0, 0};
    tbl[4]  = '{0, 3,   2, 482,   0, 1, 1, 2, 1};
    tbl[5]  = '{0, 3,  46, 574,  92, 1, 1, 0, 0};
    tbl[6]  = '{0, 3,   2, 576,  96, 0, 1, 4, 1};
    tbl[7]  = '{0, 1,   2, 574,  98, 0, 1, 0, 0};
    tbl[8]  = '{0, 2,   2, 571, 101, 0, 1, 0, 0};
    tbl[9]  = '{1, 3,   8, 316,   4, 1, 0, 0, 0};
    tbl[10] = '{1, 3,   2, 320,   0, 1, 1, 2, 1};
    tbl[11] = '{1, 3, 126, 572, 252, 1, 1, 0, 0};
    tbl[12] = '{1, 3,   2, 576, 256, 0, 1, 4, 1};
    tbl[13] = '{1, 3,  78, 420, 412, 0, 1, 0, 0};
    tbl[14] = '{1, 3,   2, 416, 416, 0, 0, 1, 1};
    tbl[15] = '{1, 3, 206,   4,   4, 0, 0, 0, 0};
    tbl[16] = '{1, 0,   6,   1,   1, 0, 0, 0, 0};
    tbl[17] = '{1, 1,   2,   0,   0, 1, 1, 10, 1};
    tbl[18] = '{1, 1,   2,   2,   2, 1, 1, 0, 0};

    sel = 0; rst_n = 1'b0; rst_c_n = 1'b0;
    h_cnt = 10'd5; v_cnt = 10'd0; pause = 1'b0; speed = 2'd0;
    px = '0; py = '0;
    repeat (3) step();
    chk("rst_x", int'(x_a), 430);
    chk("rst_y", int'(y_a), 50);
    chk("rst_dir_x", int'(dx_a), 1);
    chk("rst_dir_y", int'(dy_a), 0);
    chk("rst_bounce", int'(b_a), 0);
    chk("rst_edge_hit", int'(e_a), 0);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      if (k == NA) begin
        @(negedge pclk);
        rst_n = 1'b0; sel = 1; rst_c_n = 1'b1;
      end
      apply(k);
    end

    // pause: counter held at 1 across five paused frames
    @(negedge pclk);
    rst_c_n = 1'b0; sel = 0; rst_n = 1'b0;
    step(); rst_n = 1'b1; speed = 2'd0;
    run_frame();
    chk("t4_pre_x", int'(x_a), 430);
    pause = 1'b1;
    for (int f = 0; f < 5; f++) begin
      run_frame();
      chk($sformatf("t4_paused%0d_x", f), int'(x_a), 430);
      chk($sformatf("t4_paused%0d_y", f), int'(y_a), 50);
    end
    pause = 1'b0;
    run_frame();
    chk("t4_resume_x", int'(x_a), 431);
    chk("t4_resume_y", int'(y_a), 49);
    run_frame();
    chk("t4_idle_x", int'(x_a), 431);
    run_frame();
    chk("t4_next_x", int'(x_a), 432);
    chk("t4_next_y", int'(y_a), 48);

    // async reset while the FSM sits in CALC
    run_frame();
    @(negedge pclk); h_cnt = 10'd0; v_cnt = 10'd480;
    @(posedge pclk); #1 h_cnt = 10'd1;
    @(posedge pclk); #3 rst_n = 1'b0;
    #1;
    chk("t5_x", int'(x_a), 430);
    chk("t5_y", int'(y_a), 50);
    chk("t5_dir_x", int'(dx_a), 1);
    chk("t5_dir_y", int'(dy_a), 0);
    chk("t5_bounce", int'(b_a), 0);
    chk("t5_edge_hit", int'(e_a), 0);
    b0 = bcnt;
    repeat (4) step();
    chk("t5_no_bounce_cycles", bcnt - b0, 0);
    chk("t5_held_x", int'(x_a), 430);
    rst_n = 1'b1; h_cnt = 10'd5; v_cnt = 10'd0;

    // latency: new position visible 3 pclk after the tick-registering edge
    run_frame();
    @(negedge pclk); h_cnt = 10'd0; v_cnt = 10'd480;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk); #1;
      if (i == 0) h_cnt = 10'd1;
      if (lat < 0 && x_a != 10'd430) lat = i;
    end
    chk("lat_cycles", lat, 3);
    chk("lat_x", int'(x_a), 431);
    @(negedge pclk); h_cnt = 10'd5; v_cnt = 10'd0;

    // long run: moves only in blanking and always in range
    @(negedge pclk); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    nchg = 0;
    mon_en = 1;
    for (int f = 0; f < 1000; f++) begin
      speed = 2'((f / 2) % 4);
      run_frame();
    end
    mon_en = 0;
    chk("t6_move_count", nchg, 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logo_motion_ctrl.md
Name: logo_motion_ctrl

Overview:
- Upstream position source for the flying-logo display stage.
- Watches the pixel counters from vga_timing and advances the logo's top-left coordinate once per N frames.
- Bounces the logo off the edges of the 640x480 active area.
- Updates only during vertical blanking, so a displayed frame never shows a half-moved logo. Outputs feed the display stage's logo-area compare directly.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- LOGO_W, 64, logo width in pixels
- LOGO_H, 64, logo height in lines
- INIT_X, 430, reset x coordinate; must be <= H_ACTIVE-LOGO_W
- INIT_Y, 50, reset y coordinate; must be <= V_ACTIVE-LOGO_H
- FRAMES_PER_STEP, 2, frames between moves; legal range 1..255

Ports:
- pclk  in  1  pixel clock (25 MHz); the block's only clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- h_cnt  in  10  current column from vga_timing
- v_cnt  in  10  current line from vga_timing
- pause  in  1  1 = freeze motion; frame counter held
- speed  in  2  step size per move = speed+1 pixels (1..4)
- logo_x  out  10  logo left column
- logo_y  out  10  logo top line
- dir_x  out  1  1 = moving right (+x), 0 = moving left
- dir_y  out  1  1 = moving down (+y), 0 = moving up
- bounce  out  1  one-cycle pulse when any edge is hit
- edge_hit  out  4  {left,right,top,bottom} edges hit on the last move; held until the next move

Behaviour:
- Reset (async, rst=0):
  - logo_x=INIT_X, logo_y=INIT_Y
  - dir_x=1, dir_y=0
  - bounce=0, edge_hit=0
  - frame counter=0, FSM=WAIT
- XMAX=H_ACTIVE-LOGO_W (576); YMAX=V_ACTIVE-LOGO_H (416); all arithmetic is 11-bit to avoid wrap.
- frame_tick: 1-cycle pulse when h_cnt==0 && v_cnt==V_ACTIVE (first blanking line). Exactly one per frame.
- FSM WAIT / CALC / COMMIT:
  - WAIT, on frame_tick:
    - if pause: stay in WAIT; counter unchanged.
    - else if counter==FRAMES_PER_STEP-1: counter=0, go to CALC.
    - else: counter+1, stay in WAIT.
  - CALC:
    - latch s=speed+1.
    - compute candidate nx = dir_x ? x+s : x-s, and ny likewise, as signed 11-bit values.
    - next state is COMMIT.
  - COMMIT, x axis:
    - if dir_x && nx>=XMAX: x=XMAX, dir_x=0, right hit.
    - if !dir_x && nx<=0: x=0, dir_x=1, left hit.
    - else x=nx.
  - COMMIT, y axis: same rule with YMAX, bottom/top.
  - COMMIT, flags: edge_hit updated; bounce=1 for this cycle iff any hit. Next state is WAIT.
- Corner: both axes clamp and both directions flip in the same COMMIT; bounce pulses once; edge_hit has two bits set.
- Latency: logo_x/logo_y change 3 pclk after the qualifying frame_tick, always inside blanking. The display stage sees the new position from the next active frame.
- pause asserted during CALC/COMMIT: the in-flight move completes; pause is only sampled in WAIT.
- speed change mid-move: takes effect at the next CALC.
- Exact landing: a position already at 0 or XMAX with direction pointing outward cannot occur after reset. COMMIT always flips at the boundary.
- Reset mid-operation: immediate return to reset values; no bounce pulse is emitted.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE/V_ACTIVE constants.
  - FSM state enum (WAIT, CALC, COMMIT).
  - Edge-bit index constants (EDGE_L=3, EDGE_R=2, EDGE_T=1, EDGE_B=0).
- One sub-module: vga_frame_tick (h_cnt/v_cnt compare to the frame_tick pulse), reusable by other per-frame blocks.

Test Plan:
1. Release reset, speed=0, no pause, run 2 frames. Required: first move at frame 2; logo_x=431, logo_y=49, bounce=0.
2. Start at x=574, dir_x=1, speed=3. Required: next move sets x=576, dir_x=0, edge_hit=0100, one-cycle bounce.
3. Corner case at x=1, y=1, dir_x=0, dir_y=0, speed=1. Required: x=0, y=0, dir_x=1, dir_y=1, edge_hit=1010, single bounce pulse.
4. Assert pause for 5 frames, then release. Required: position constant throughout the pause; counter resumes from its held value; moves stay on FRAMES_PER_STEP cadence.
5. Drive rst=0 asynchronously during CALC. Required: outputs return to 430/50/1/0 without a pclk edge; no bounce pulse.
6. Monitor logo_x/logo_y over 1000 frames. Required: changes occur only when v_cnt>=480; values always stay within 0..576 and 0..416.
